// File: rtl/k423_pipe_pkg.sv
// Shared types for the k423 inter-stage pipeline registers.
// Each boundary payload is a packed struct so a stage is sized with $bits(<struct>).
package k423_pipe_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    typedef logic [1:0] pipe_occ_t;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluSrl,
        AluSra,
        AluSlt,
        AluSltu,
        AluLui,
        AluAuipc
    } alu_op_e;

    typedef enum logic [1:0] {
        MemByte,
        MemHalf,
        MemWord,
        MemDouble
    } mem_size_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            pred_taken;
    } if2id_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        alu_op_e           alu_op;
        logic              mem_rd;
        logic              mem_wr;
        mem_size_e         mem_size;
        logic              wb_en;
    } id2ex_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   store_val;
        logic [REG_AW-1:0] rd;
        logic              mem_rd;
        logic              mem_wr;
        mem_size_e         mem_size;
        logic              wb_en;
    } ex2mem_t;

    typedef struct packed {
        logic [XLEN-1:0]   wb_val;
        logic [REG_AW-1:0] rd;
        logic              wb_en;
    } mem2wb_t;

    // Number of held entries given the two valid flags.
    function automatic pipe_occ_t occ_count(input logic main_vld, input logic skid_vld);
        return pipe_occ_t'({1'b0, main_vld}) + pipe_occ_t'({1'b0, skid_vld});
    endfunction

endpackage

// File: rtl/k423_pipe_entry.sv
// One pipeline slot: a valid flag plus a payload register with load and clear enables.
// Clear wins over load so a flushed slot never keeps stale data.
module k423_pipe_entry
    import k423_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              vld_d_i,
    input  logic              ld_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/k423_pipe_stage.sv
// Parametrised valid/ready pipeline register with optional skid entry, flush and stall.
// Main entry always drives the downstream side; the skid entry only absorbs one extra item.
module k423_pipe_stage
    import k423_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter bit          SKID_EN  = 1'b1,
    parameter bit          CLR_DATA = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              up_vld_i,
    output logic              up_rdy_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_vld_o,
    input  logic              dn_rdy_i,
    output logic [DATA_W-1:0] dn_data_o,
    output pipe_occ_t         occ_o
);

    logic              main_vld;
    logic [DATA_W-1:0] main_data;
    logic              main_vld_d;
    logic              main_ld;
    logic              main_clr;
    logic [DATA_W-1:0] main_src;

    logic              skid_vld;
    logic [DATA_W-1:0] skid_data;
    logic              skid_vld_d;
    logic              skid_ld;
    logic              skid_clr;

    logic              up_rdy;
    logic              acc;
    logic              pop;

    generate
        if (SKID_EN) begin : g_rdy_skid
            assign up_rdy = ~skid_vld & ~stall_i;
        end else begin : g_rdy_single
            assign up_rdy = (~main_vld | dn_rdy_i) & ~stall_i;
        end
    endgenerate

    // A flush discards the incoming item even though ready was offered.
    assign acc = up_vld_i & up_rdy & ~flush_i;
    assign pop = main_vld & dn_rdy_i;

    always_comb begin
        main_vld_d = main_vld;
        main_ld    = 1'b0;
        main_clr   = 1'b0;
        main_src   = up_data_i;
        skid_vld_d = skid_vld;
        skid_ld    = 1'b0;
        skid_clr   = 1'b0;

        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_clr   = CLR_DATA;
            skid_clr   = CLR_DATA;
        end else if (!main_vld || pop) begin
            // Main is free next cycle: refill from skid first to keep FIFO order.
            if (skid_vld) begin
                main_vld_d = 1'b1;
                main_ld    = 1'b1;
                main_src   = skid_data;
                skid_vld_d = 1'b0;
                skid_clr   = CLR_DATA;
            end else if (acc) begin
                main_vld_d = 1'b1;
                main_ld    = 1'b1;
            end else begin
                main_vld_d = 1'b0;
                main_clr   = CLR_DATA;
            end
        end else if (acc) begin
            skid_vld_d = 1'b1;
            skid_ld    = 1'b1;
        end
    end

    k423_pipe_entry #(
        .DATA_W(DATA_W)
    ) u_main (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .vld_d_i(main_vld_d),
        .ld_i   (main_ld),
        .clr_i  (main_clr),
        .data_i (main_src),
        .vld_o  (main_vld),
        .data_o (main_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            k423_pipe_entry #(
                .DATA_W(DATA_W)
            ) u_skid (
                .clk_i  (clk_i),
                .rst_n_i(rst_n_i),
                .vld_d_i(skid_vld_d),
                .ld_i   (skid_ld),
                .clr_i  (skid_clr),
                .data_i (up_data_i),
                .vld_o  (skid_vld),
                .data_o (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid;
            assign skid_vld    = 1'b0;
            assign skid_data   = '0;
            assign unused_skid = ^{skid_vld_d, skid_ld, skid_clr};
        end
    endgenerate

    assign up_rdy_o  = up_rdy;
    assign dn_vld_o  = main_vld;
    assign dn_data_o = main_data;
    assign occ_o     = occ_count(main_vld, skid_vld);

    skid_implies_main: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        skid_vld |-> main_vld);

    // Held output must not change under backpressure unless killed.
    hold_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (main_vld & ~dn_rdy_i & ~flush_i) |=> $stable(main_data));

endmodule

// File: tb/tb_k423_pipe_stage.sv
// Scoreboard bench: two stages (with and without skid) share stimulus; each has a
// bounded-FIFO reference model whose expected items are popped by a negedge monitor.
module tb_k423_pipe_stage;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       flush_i;
    logic       stall_i;
    logic       up_vld_i;
    logic       dn_rdy_i;
    logic [7:0] up_data_i;

    logic [1:0] up_rdy;
    logic [1:0] dn_vld;
    logic [7:0] dn_data [2];
    logic [1:0] occ [2];

    // Index 0: SKID_EN=1 (capacity 2), index 1: SKID_EN=0 (capacity 1).
    logic [7:0] exq [2][$];
    logic [1:0] exp_rdy;
    logic [1:0] acc_p;
    logic [1:0] flush_p;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    k423_pipe_stage #(
        .DATA_W  (8),
        .SKID_EN (1'b1),
        .CLR_DATA(1'b1)
    ) u_dut_skid (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .flush_i  (flush_i),
        .stall_i  (stall_i),
        .up_vld_i (up_vld_i),
        .up_rdy_o (up_rdy[0]),
        .up_data_i(up_data_i),
        .dn_vld_o (dn_vld[0]),
        .dn_rdy_i (dn_rdy_i),
        .dn_data_o(dn_data[0]),
        .occ_o    (occ[0])
    );

    k423_pipe_stage #(
        .DATA_W  (8),
        .SKID_EN (1'b0),
        .CLR_DATA(1'b1)
    ) u_dut_single (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .flush_i  (flush_i),
        .stall_i  (stall_i),
        .up_vld_i (up_vld_i),
        .up_rdy_o (up_rdy[1]),
        .up_data_i(up_data_i),
        .dn_vld_o (dn_vld[1]),
        .dn_rdy_i (dn_rdy_i),
        .dn_data_o(dn_data[1]),
        .occ_o    (occ[1])
    );

    task automatic chk(input string name, input int dut, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%0h expected=%0h t=%0t", name, dut, act, exp, $time);
        end
    endtask

    // Ready as the stage's rules define it, from model occupancy only.
    function automatic logic model_rdy(input int i, input logic r, input logic s);
        int n;
        n = exq[i].size();
        if (i == 0) return (n < 2) && !s;
        return ((n == 0) || r) && !s;
    endfunction

    // Commit the edge just taken into the model, then drive the next cycle's inputs.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic s,
                        input logic f);
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (flush_p[i]) exq[i].delete();
            else if (acc_p[i]) exq[i].push_back(up_data_i);
        end
        up_vld_i  = v;
        up_data_i = d;
        dn_rdy_i  = r;
        stall_i   = s;
        flush_i   = f;
        for (int i = 0; i < 2; i++) begin
            exp_rdy[i] = model_rdy(i, r, s);
            acc_p[i]   = v & exp_rdy[i] & ~f;
            flush_p[i] = f;
        end
    endtask

    task automatic async_reset();
        @(negedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_dn_vld", i, dn_vld[i], 0);
            chk("rst_occ", i, occ[i], 0);
            chk("rst_dn_data", i, dn_data[i], 0);
            chk("rst_up_rdy", i, up_rdy[i], 1);
            exq[i].delete();
        end
        up_vld_i = 1'b0;
        dn_rdy_i = 1'b0;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        exp_rdy  = 2'b11;
        acc_p    = 2'b00;
        flush_p  = 2'b00;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                chk("dn_vld", i, dn_vld[i], exq[i].size() != 0);
                chk("occ", i, occ[i], exq[i].size());
                chk("up_rdy", i, up_rdy[i], exp_rdy[i]);
                if (!dn_vld[i]) begin
                    chk("bubble_data", i, dn_data[i], 0);
                end else if (dn_rdy_i) begin
                    if (exq[i].size() == 0) chk("unexpected_pop", i, dn_vld[i], 0);
                    else chk("dn_data", i, dn_data[i], exq[i].pop_front());
                end
            end
        end
    end

    initial begin
        rst_n_i   = 1'b0;
        up_vld_i  = 1'b0;
        up_data_i = 8'h00;
        dn_rdy_i  = 1'b0;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        exp_rdy   = 2'b11;
        acc_p     = 2'b00;
        flush_p   = 2'b00;

        #3;
        for (int i = 0; i < 2; i++) begin
            chk("reset_dn_vld", i, dn_vld[i], 0);
            chk("reset_occ", i, occ[i], 0);
            chk("reset_dn_data", i, dn_data[i], 0);
            chk("reset_up_rdy", i, up_rdy[i], 1);
        end
        #9;
        rst_n_i = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Streaming 0x01..0x10.
        for (int k = 1; k <= 16; k++) step(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Backpressure: A1 appears with dn_rdy low, A3 held upstream until taken.
        step(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4 && !acc_p[0]; k++) step(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Load-use bubble.
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush while full.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush and stall together.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Async reset while the skid stage is full.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        @(negedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
